// File: rtl/spi_config_ctrl_pkg.sv
// spi_config_pkg: shared types and constants for the SPI configuration
// controller.
//   state_e        - frame FSM states
//   FRAME_BITS     - bits in one complete write frame
//   ADDR_*         - register map of the configuration registers
//   frame_is_write - helper that extracts the R/W flag of a frame
package spi_config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_DUTY      = 7'd4;

  // Bit 15 of a frame set means the controller wants a register write.
  function automatic logic frame_is_write(input logic [FRAME_BITS-1:0] frame);
    return frame[FRAME_BITS-1];
  endfunction

endpackage

// File: rtl/spi_config_ctrl_if.sv
// spi_config_ctrl_if: the three SPI pins between an off-chip controller
// and the configuration block.
//   sclk - SPI clock (mode 0), copi - serial data MSB first,
//   ncs  - active-low chip select
//   master modport drives the pins, slave modport receives them.
interface spi_config_ctrl_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_config_ctrl_sync_ff.sv
// sync_ff: multi-stage synchronizer bringing an asynchronous input into
// the clk domain.
//   clk, rst_n - system clock, synchronous active-low reset
//   d          - asynchronous input
//   q          - output of the last synchronizer stage
// RST_VAL is the value every stage takes in reset, so idle-high pins
// (chip select) do not create a spurious edge when reset releases.
module sync_ff #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Flop chain: stage 0 samples the pin, later stages resolve metastability.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= RST_VAL;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/spi_config_ctrl.sv
// spi_config_ctrl: receives 16-bit SPI write frames and commits them to
// five 8-bit configuration registers feeding the PWM peripheral.
//   clk, rst_n        - system clock, synchronous active-low reset
//   spi               - SPI pins (slave modport): sclk, copi, ncs
//   en_reg_out_7_0    - register 0x00     en_reg_out_15_8 - register 0x01
//   en_reg_pwm_7_0    - register 0x02     en_reg_pwm_15_8 - register 0x03
//   pwm_duty_cycle    - register 0x04
//   cfg_wr            - one-cycle pulse on every register commit
//   frame_err         - one-cycle pulse when a frame has the wrong length
module spi_config_ctrl
  import spi_config_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_config_ctrl_if.slave     spi,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle,
  output logic                 cfg_wr,
  output logic                 frame_err
);

  localparam logic [6:0] MAX_ADDR_L  = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_FULL    = 5'(FRAME_BITS);
  // Saturating one past a full frame keeps any over-long frame distinct
  // from a valid one without letting the counter wrap back to 16.
  localparam logic [4:0] CNT_SAT     = 5'(FRAME_BITS + 1);

  logic sclk_sync_s;
  logic copi_sync_s;
  logic ncs_sync_s;
  logic sclk_hist_r;
  logic ncs_hist_r;
  logic sclk_rise_s;
  logic ncs_rise_s;
  logic ncs_fall_s;

  state_e                  state_r;
  logic [FRAME_BITS-1:0]   shift_r;
  logic [4:0]              cnt_r;
  logic [6:0]              addr_s;
  logic [7:0]              data_s;

  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.sclk),
    .q     (sclk_sync_s)
  );

  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.copi),
    .q     (copi_sync_s)
  );

  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.ncs),
    .q     (ncs_sync_s)
  );

  // History flops: one extra stage behind each synchronizer for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_hist_r <= 1'b0;
      ncs_hist_r  <= 1'b1;
    end else begin
      sclk_hist_r <= sclk_sync_s;
      ncs_hist_r  <= ncs_sync_s;
    end
  end

  assign sclk_rise_s = sclk_sync_s & ~sclk_hist_r;
  assign ncs_rise_s  = ncs_sync_s & ~ncs_hist_r;
  assign ncs_fall_s  = ~ncs_sync_s & ncs_hist_r;

  assign addr_s = shift_r[14:8];
  assign data_s = shift_r[7:0];

  // Frame FSM, frame decode and register file with registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      shift_r         <= {FRAME_BITS{1'b0}};
      cnt_r           <= 5'd0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      cfg_wr          <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      cfg_wr    <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // sclk edges seen here belong to no frame and are dropped.
          if (ncs_fall_s) begin
            shift_r <= {FRAME_BITS{1'b0}};
            cnt_r   <= 5'd0;
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Deselect takes priority over a coincident clock edge.
          if (ncs_rise_s) begin
            state_r <= ST_COMMIT;
          end else if (sclk_rise_s) begin
            shift_r <= {shift_r[FRAME_BITS-2:0], copi_sync_s};
            if (cnt_r != CNT_SAT) begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
        end
        ST_COMMIT: begin
          state_r <= ST_IDLE;
          if (cnt_r == CNT_FULL) begin
            // Reads and out-of-range writes are dropped without a strobe.
            if (frame_is_write(shift_r) && (addr_s <= MAX_ADDR_L)) begin
              cfg_wr <= 1'b1;
              case (addr_s)
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= data_s;
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= data_s;
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= data_s;
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= data_s;
                ADDR_DUTY:      pwm_duty_cycle  <= data_s;
                default:        ;
              endcase
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_ctrl.sv
// tb_spi_config_ctrl: drives SPI frames with randomized pin timing and
// checks every clk cycle against a transaction-level model of the
// register map (each frame decoded once, its effect scheduled at the
// commit edge).
module tb_spi_config_ctrl;

  localparam int SYNC = 2;

  logic clk;
  logic rst_n;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic cfg_wr, frame_err;

  spi_config_ctrl_if spi_bus ();

  spi_config_ctrl #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi_bus),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .cfg_wr          (cfg_wr),
    .frame_err       (frame_err)
  );

  // Period 20: posedges at 10 mod 20, negedges at 0 mod 20.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    longint     due;
    int         kind;   // 0 none, 1 write, 2 length error
    int         addr;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] m_reg [5];
  longint     cyc = 0;
  bit         rst_seen = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         cnt_wr = 0;
  int         cnt_err = 0;
  longint     last_wr_cyc = 0;
  longint     rise_cyc = 0;
  logic [7:0] act_regs [5];
  bit         exp_wr, exp_err;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_seen = !rst_n;
  end

  // Compare process: apply due model events, then check every output.
  always @(negedge clk) begin
    exp_wr  = 1'b0;
    exp_err = 1'b0;
    if (rst_seen) begin
      for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
      evq.delete();
    end else begin
      while (evq.size() > 0 && evq[0].due <= cyc) begin
        if (evq[0].due == cyc) begin
          if (evq[0].kind == 1) begin
            exp_wr = 1'b1;
            m_reg[evq[0].addr] = evq[0].data;
          end else if (evq[0].kind == 2) begin
            exp_err = 1'b1;
          end
        end
        void'(evq.pop_front());
      end
    end
    act_regs[0] = en_reg_out_7_0;
    act_regs[1] = en_reg_out_15_8;
    act_regs[2] = en_reg_pwm_7_0;
    act_regs[3] = en_reg_pwm_15_8;
    act_regs[4] = pwm_duty_cycle;
    for (int i = 0; i < 5; i++) chk($sformatf("reg%0d", i), act_regs[i], m_reg[i]);
    chk("cfg_wr", {7'd0, cfg_wr}, {7'd0, exp_wr});
    chk("frame_err", {7'd0, frame_err}, {7'd0, exp_err});
    if (cfg_wr === 1'b1) begin
      cnt_wr++;
      last_wr_cyc = cyc;
    end
    if (frame_err === 1'b1) cnt_err++;
  end

  // Delay that never lands on an active clk edge.
  task automatic step(input int d);
    longint t;
    t = d;
    if ((($time + t) % 20) == 10) t++;
    #(t);
  endtask

  function automatic int w();
    return 41 + int'($urandom_range(0, 30));
  endfunction

  // Wait until any pending commit has landed, stopping off the edges.
  task automatic settle();
    repeat (SYNC + 6) @(posedge clk);
    #3;
  endtask

  // Send nbits of bits (MSB first). If rst_after >= 0, pulse reset for one
  // clk cycle after that many bits while ncs stays low.
  task automatic send_frame(input logic [16:0] bits, input int nbits, input int rst_after);
    int   eff;
    ev_t  e;
    logic [15:0] f;
    eff = nbits;
    spi_bus.ncs = 1'b0;
    step(w());
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bus.copi = bits[i];
      step(w());
      spi_bus.sclk = 1'b1;
      step(w());
      spi_bus.sclk = 1'b0;
      if (nbits - i == rst_after) begin
        step(w());
        rst_n = 1'b0;
        @(posedge clk);
        step(5);
        rst_n = 1'b1;
        chk("rst_out_lo", en_reg_out_7_0, 8'h00);
        chk("rst_pwm_lo", en_reg_pwm_7_0, 8'h00);
        chk("rst_pwm_hi", en_reg_pwm_15_8, 8'h00);
        chk("rst_duty", pwm_duty_cycle, 8'h00);
        eff = nbits - rst_after;
        step(60);
      end
    end
    step(w());
    spi_bus.ncs = 1'b1;
    rise_cyc = cyc;
    f = bits[15:0];
    e.due  = cyc + SYNC + 2;
    e.addr = int'(f[14:8]);
    e.data = f[7:0];
    if (eff != 16) e.kind = 2;
    else if (f[15] && f[14:8] <= 7'd4) e.kind = 1;
    else e.kind = 0;
    if (e.addr > 4) e.addr = 0;
    evq.push_back(e);
    step(w());
    spi_bus.copi = 1'b0;
  endtask

  int         wr0, er0;
  logic [16:0] fr;

  initial begin
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    rst_n = 1'b0;
    spi_bus.ncs  = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.copi = 1'b0;
    repeat (3) @(posedge clk);
    step(3);
    rst_n = 1'b1;
    step(40);

    // Single write to 0x00 with latency pinned to 4 edges.
    wr0 = cnt_wr; er0 = cnt_err;
    send_frame(17'h080F0, 16, -1);
    settle();
    chk("t1_out_lo", en_reg_out_7_0, 8'hF0);
    chk("t1_out_hi", en_reg_out_15_8, 8'h00);
    chk("t1_duty", pwm_duty_cycle, 8'h00);
    chk("t1_wr_cnt", 8'(cnt_wr - wr0), 8'd1);
    chk("t1_latency", 8'(last_wr_cyc - rise_cyc), 8'd4);

    // Back-to-back writes.
    wr0 = cnt_wr;
    send_frame(17'h08480, 16, -1);
    send_frame(17'h0835A, 16, -1);
    settle();
    chk("t2_duty", pwm_duty_cycle, 8'h80);
    chk("t2_pwm_hi", en_reg_pwm_15_8, 8'h5A);
    chk("t2_wr_cnt", 8'(cnt_wr - wr0), 8'd2);

    // Read frame and out-of-range write are silent.
    wr0 = cnt_wr; er0 = cnt_err;
    send_frame(17'h000AA, 16, -1);
    send_frame(17'h085FF, 16, -1);
    settle();
    chk("t3_wr_cnt", 8'(cnt_wr - wr0), 8'd0);
    chk("t3_err_cnt", 8'(cnt_err - er0), 8'd0);
    chk("t3_out_lo", en_reg_out_7_0, 8'hF0);

    // Short and long frames to address 0x01.
    wr0 = cnt_wr; er0 = cnt_err;
    send_frame(17'h040E7, 15, -1);
    send_frame(17'h181E7, 17, -1);
    settle();
    chk("t4_out_hi", en_reg_out_15_8, 8'h00);
    chk("t4_err_cnt", 8'(cnt_err - er0), 8'd2);
    chk("t4_wr_cnt", 8'(cnt_wr - wr0), 8'd0);

    // Reset mid-frame, then a clean frame.
    er0 = cnt_err;
    send_frame(17'h08233, 16, 8);
    settle();
    chk("t5_err_cnt", 8'(cnt_err - er0), 8'd1);
    chk("t5_pwm_lo_partial", en_reg_pwm_7_0, 8'h00);
    send_frame(17'h08233, 16, -1);
    settle();
    chk("t5_pwm_lo", en_reg_pwm_7_0, 8'h33);

    // Randomized frames and pin phases.
    for (int n = 0; n < 24; n++) begin
      fr = 17'h00000;
      fr[15]   = ($urandom_range(0, 3) != 0);
      fr[14:8] = 7'($urandom_range(0, 6));
      fr[7:0]  = 8'($urandom);
      send_frame(fr, 16, -1);
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_config_ctrl.md
# spi_config_ctrl

Configuration controller for the PWM peripheral. It receives 16-bit write frames from an off-chip SPI controller on three asynchronous pins and synchronizes them into the system clock domain. It decodes each frame and commits it to one of five 8-bit configuration registers, which directly drive the output-enable, PWM-enable and duty-cycle inputs of `pwm_peripheral` in the top-level wrapper.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `sclk`, `copi` and `ncs`. Legal range is 2 or more.
- `MAX_ADDR`, 4: highest writable register address.

Ports:
- `clk`  in  1  system clock. The block has one clock domain.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `sclk`  in  1  SPI clock, asynchronous to `clk`. SPI mode 0: data is sampled on the `sclk` rising edge.
- `copi`  in  1  SPI data in, MSB first, asynchronous.
- `ncs`  in  1  SPI chip select, active-low, asynchronous.
- `en_reg_out_7_0`  out  8  address 0x00.
- `en_reg_out_15_8`  out  8  address 0x01.
- `en_reg_pwm_7_0`  out  8  address 0x02.
- `en_reg_pwm_15_8`  out  8  address 0x03.
- `pwm_duty_cycle`  out  8  address 0x04.
- `cfg_wr`  out  1  one-cycle pulse on every register commit.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded for bad length.

## Operation
- Frame format, 16 bits, MSB first:
  - bit15: R/W. 1 means write.
  - bits14:8: address.
  - bits7:0: data.
- Input conditioning:
  - Each pin passes through a `SYNC_STAGES` flop chain.
  - Edges are detected by comparing the last synchronizer stage against one further history flop.
- State machine:
  - IDLE: wait for a synchronized `ncs` falling edge. On that edge, clear the shift register and bit counter, then go to SHIFT.
  - SHIFT: on each synchronized `sclk` rising edge, shift the synchronized `copi` into the LSB and increment the bit counter.
    - The bit counter is 5 bits and saturates at 17.
    - A synchronized `ncs` rising edge moves to COMMIT.
  - COMMIT, one cycle:
    - Count == 16, bit15 == 1 and address <= `MAX_ADDR`: write the data byte to the addressed register and pulse `cfg_wr`.
    - Count == 16 with bit15 == 0, or with address > `MAX_ADDR`: silent discard. No register change, no pulse.
    - Count != 16: discard and pulse `frame_err`.
    - Always return to IDLE.
- Read frames are accepted on the wire and ignored. The block has no CIPO.
- Registers hold their value until overwritten or reset. Unaddressed registers never change.

## Timing
- Reset values: all five registers 0x00, `cfg_wr` 0, `frame_err` 0, state IDLE, counter 0, all synchronizer and history flops 1 for `ncs` and 0 for `sclk`/`copi`.
- Reset mid-frame: the partial frame is lost.
  - Because the `ncs` flops reset to 1, an `ncs` that is still low after reset produces a falling edge.
  - That frame is partial; its length mismatch yields `frame_err` at its end.
- Commit latency: the register output and `cfg_wr` update on clk edge `SYNC_STAGES + 2` after the first synchronizer flop samples the `ncs` high. With the default setting this is edge 4.
- `cfg_wr` and `frame_err` are each high for exactly 1 cycle and are mutually exclusive.
- Input timing requirement: each `sclk` high phase and low phase must last at least 2 clk periods. Faster `sclk` is not supported and the result is undefined.
- Simultaneous events in the same clk cycle:
  - A synchronized `ncs` rise and `sclk` rise together: the `ncs` rise wins and the `sclk` edge is not counted.
  - A synchronized `ncs` fall in SHIFT cannot occur. Any `sclk` edge while in IDLE is ignored.
- Back-to-back frames: `ncs` high time must be at least 2 clk periods so that COMMIT completes before the next falling edge is detected.

## Structure
- Package `spi_config_pkg` holds:
  - the state enum (IDLE, SHIFT, COMMIT);
  - `FRAME_BITS = 16`;
  - address constants `ADDR_EN_OUT_LO = 0`, `ADDR_EN_OUT_HI = 1`, `ADDR_EN_PWM_LO = 2`, `ADDR_EN_PWM_HI = 3`, `ADDR_DUTY = 4`.
- Sub-module `sync_ff`, parameterized by width and stages, with its own reset value parameter. It is instantiated once per pin.
- Frame decode and register file stay in the top of this block.

## Test plan
- Write 0x00 = 0xF0 (frame 0x80F0) → `en_reg_out_7_0` = 0xF0 at commit edge; `cfg_wr` pulses once; other registers stay 0x00.
- Write 0x04 = 0x80 (frame 0x8480), then 0x03 = 0x5A (frame 0x835A) back-to-back with minimum `ncs` gap → `pwm_duty_cycle` = 0x80 and `en_reg_pwm_15_8` = 0x5A; exactly two `cfg_wr` pulses.
- Read frame 0x00AA and write to address 0x05 (frame 0x85FF) → all registers unchanged; no `cfg_wr`, no `frame_err`.
- 15-bit frame, then 17-bit frame (both with write bit set, address 0x01) → `en_reg_out_15_8` unchanged; `frame_err` pulses twice.
- Assert `rst_n` low for 1 cycle after 8 bits of frame 0x8233 with `ncs` held low → all outputs 0x00 on the next edge.
  - Completing that frame → `frame_err`.
  - A subsequent clean 0x8233 → `en_reg_pwm_7_0` = 0x33.
- Randomized `sclk`/`ncs` phase against `clk` at the minimum 2-cycle high/low width → every 16-bit write commits correctly, with latency exactly `SYNC_STAGES + 2` from `ncs` rise.
